// File: rtl/timer_out_ctrl_n.sv
`default_nettype none
// ============================================================================
//  Module   : timer_out_ctrl_n
//  Purpose  : Registered output and interrupt control for an N-channel 8-bit
//             timer bank. Per channel it owns the compare-match / overflow
//             status flags and their interrupt requests, drives the TMO pin
//             from compare-match events, builds the counter-clear request
//             (including a synchronised external TMRI reset) and contributes
//             to a shared ADC trigger pulse.
//  Ports    : clk, rst              - clock, asynchronous active-high reset
//             tmri[N]               - external counter-reset pins (async)
//             tcr/tccr/tcsr[N*BW]   - per-channel control registers
//             compare_match_a/b[N], overflow[N]        - event strobes
//             flag_clr_cmfa/cmfb/ovf[N]                - flag clear strobes
//             cmfa/cmfb/ovf[N]      - status flags
//             cmia/cmib/ovi[N]      - interrupt requests
//             counter_clear[N]      - counter clear request (combinational)
//             tmo[N]                - timer output pins
//             adc_request           - ADC start pulse
//             clock_select[N*CSW]   - {CKS2..0, ICKS1..0} per channel
//  Revision : 1.0 - initial release
// ============================================================================
module timer_out_ctrl_n #(
  parameter int                NUM_CH               = 2,
  parameter int                BIT_WIDTH            = 8,
  parameter int                CLK_SELECT_BIT_WIDTH = 5,
  parameter logic [NUM_CH-1:0] TMO_INIT             = '0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_CH-1:0]                      tmri,
  input  logic [NUM_CH*BIT_WIDTH-1:0]            tcr,
  input  logic [NUM_CH*BIT_WIDTH-1:0]            tccr,
  input  logic [NUM_CH*BIT_WIDTH-1:0]            tcsr,
  input  logic [NUM_CH-1:0]                      compare_match_a,
  input  logic [NUM_CH-1:0]                      compare_match_b,
  input  logic [NUM_CH-1:0]                      overflow,
  input  logic [NUM_CH-1:0]                      flag_clr_cmfa,
  input  logic [NUM_CH-1:0]                      flag_clr_cmfb,
  input  logic [NUM_CH-1:0]                      flag_clr_ovf,
  output logic [NUM_CH-1:0]                      cmfa,
  output logic [NUM_CH-1:0]                      cmfb,
  output logic [NUM_CH-1:0]                      ovf,
  output logic [NUM_CH-1:0]                      cmia,
  output logic [NUM_CH-1:0]                      cmib,
  output logic [NUM_CH-1:0]                      ovi,
  output logic [NUM_CH-1:0]                      counter_clear,
  output logic [NUM_CH-1:0]                      tmo,
  output logic                                   adc_request,
  output logic [NUM_CH*CLK_SELECT_BIT_WIDTH-1:0] clock_select
);

  localparam logic [1:0] c_ACT_HOLD   = 2'b00;
  localparam logic [1:0] c_ACT_LOW    = 2'b01;
  localparam logic [1:0] c_ACT_HIGH   = 2'b10;
  localparam logic [1:0] c_ACT_TOGGLE = 2'b11;

  logic [NUM_CH-1:0] w_adc_hit;
  logic              r_adc;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [BIT_WIDTH-1:0] w_tcr;
      logic [BIT_WIDTH-1:0] w_tccr;
      logic [BIT_WIDTH-1:0] w_tcsr;
      logic [1:0]           w_act;
      logic                 w_ext_clr;
      logic                 w_unused;
      logic                 r_cmfa;
      logic                 r_cmfb;
      logic                 r_ovf;
      logic                 r_tmo;
      logic                 r_s1;
      logic                 r_s2;
      logic                 r_s3;

      assign w_tcr  = tcr [gi*BIT_WIDTH +: BIT_WIDTH];
      assign w_tccr = tccr[gi*BIT_WIDTH +: BIT_WIDTH];
      assign w_tcsr = tcsr[gi*BIT_WIDTH +: BIT_WIDTH];

      // Control bits that this block does not consume.
      assign w_unused = ^{w_tccr[BIT_WIDTH-1:4], w_tccr[2], w_tcsr[BIT_WIDTH-1:5]};

      // B takes priority only when it actually asks for something; a B match
      // with a "hold" action must not mask a simultaneous A action.
      always_comb begin
        w_act = c_ACT_HOLD;
        if (compare_match_b[gi] && (w_tcsr[3:2] != c_ACT_HOLD)) begin
          w_act = w_tcsr[3:2];
        end else if (compare_match_a[gi]) begin
          w_act = w_tcsr[1:0];
        end
      end

      // TMRIS selects level clear (s2) or rising-edge pulse (s2 & ~s3).
      assign w_ext_clr = w_tccr[3] ? r_s2 : (r_s2 & ~r_s3);

      always_comb begin
        case (w_tcr[4:3])
          2'b01:   counter_clear[gi] = compare_match_a[gi];
          2'b10:   counter_clear[gi] = compare_match_b[gi];
          2'b11:   counter_clear[gi] = w_ext_clr;
          default: counter_clear[gi] = 1'b0;
        endcase
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cmfa <= 1'b0;
          r_cmfb <= 1'b0;
          r_ovf  <= 1'b0;
          r_tmo  <= TMO_INIT[gi];
          r_s1   <= 1'b0;
          r_s2   <= 1'b0;
          r_s3   <= 1'b0;
        end else begin
          // Event set dominates a same-cycle clear.
          if (compare_match_a[gi])    r_cmfa <= 1'b1;
          else if (flag_clr_cmfa[gi]) r_cmfa <= 1'b0;
          if (compare_match_b[gi])    r_cmfb <= 1'b1;
          else if (flag_clr_cmfb[gi]) r_cmfb <= 1'b0;
          if (overflow[gi])           r_ovf  <= 1'b1;
          else if (flag_clr_ovf[gi])  r_ovf  <= 1'b0;

          case (w_act)
            c_ACT_LOW:    r_tmo <= 1'b0;
            c_ACT_HIGH:   r_tmo <= 1'b1;
            c_ACT_TOGGLE: r_tmo <= ~r_tmo;
            default:      r_tmo <= r_tmo;
          endcase

          r_s1 <= tmri[gi];
          r_s2 <= r_s1;
          r_s3 <= r_s2;
        end
      end

      assign cmfa[gi] = r_cmfa;
      assign cmfb[gi] = r_cmfb;
      assign ovf[gi]  = r_ovf;
      assign cmia[gi] = r_cmfa & w_tcr[6];
      assign cmib[gi] = r_cmfb & w_tcr[7];
      assign ovi[gi]  = r_ovf  & w_tcr[5];
      assign tmo[gi]  = r_tmo;

      assign w_adc_hit[gi] = w_tcsr[4] & compare_match_a[gi];

      assign clock_select[gi*CLK_SELECT_BIT_WIDTH +: CLK_SELECT_BIT_WIDTH] =
        {w_tcr[2:0], w_tccr[1:0]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_adc <= 1'b0;
    else     r_adc <= |w_adc_hit;
  end

  assign adc_request = r_adc;

endmodule
`default_nettype wire

// File: tb/tb_timer_out_ctrl_n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_timer_out_ctrl_n
//  Purpose  : Self-checking bench for timer_out_ctrl_n (4 channels). Directed
//             steps followed by random traffic, every output compared each
//             cycle against a behavioural model of the channel rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_timer_out_ctrl_n;

  localparam int             N    = 4;
  localparam int             BW   = 8;
  localparam int             CW   = 5;
  localparam logic [N-1:0]   INIT = 4'b0110;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    tmri;
  logic [N*BW-1:0] tcr, tccr, tcsr;
  logic [N-1:0]    compare_match_a, compare_match_b, overflow;
  logic [N-1:0]    flag_clr_cmfa, flag_clr_cmfb, flag_clr_ovf;
  logic [N-1:0]    cmfa, cmfb, ovf, cmia, cmib, ovi, counter_clear, tmo;
  logic            adc_request;
  logic [N*CW-1:0] clock_select;

  always #5 clk = ~clk;

  timer_out_ctrl_n #(
    .NUM_CH(N), .BIT_WIDTH(BW), .CLK_SELECT_BIT_WIDTH(CW), .TMO_INIT(INIT)
  ) dut (
    .clk(clk), .rst(rst), .tmri(tmri), .tcr(tcr), .tccr(tccr), .tcsr(tcsr),
    .compare_match_a(compare_match_a), .compare_match_b(compare_match_b),
    .overflow(overflow), .flag_clr_cmfa(flag_clr_cmfa),
    .flag_clr_cmfb(flag_clr_cmfb), .flag_clr_ovf(flag_clr_ovf),
    .cmfa(cmfa), .cmfb(cmfb), .ovf(ovf), .cmia(cmia), .cmib(cmib), .ovi(ovi),
    .counter_clear(counter_clear), .tmo(tmo), .adc_request(adc_request),
    .clock_select(clock_select)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state
  logic [N-1:0] m_cmfa, m_cmfb, m_ovf, m_tmo;
  logic         m_adc;
  logic [2:0]   m_hist [N];   // tmri as seen at the last three clock edges, [0] newest

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic tmo_next(input logic cur, input logic a, input logic b,
                                    input logic [3:0] os);
    logic [1:0] act;
    act = 2'b00;
    if (b && os[3:2] != 2'b00) act = os[3:2];
    else if (a)                act = os[1:0];
    case (act)
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      2'b11:   return ~cur;
      default: return cur;
    endcase
  endfunction

  task automatic model_reset();
    m_cmfa = '0; m_cmfb = '0; m_ovf = '0; m_tmo = INIT; m_adc = 1'b0;
    for (int c = 0; c < N; c++) m_hist[c] = 3'b000;
  endtask

  task automatic model_tick();
    logic hit;
    hit = 1'b0;
    for (int c = 0; c < N; c++) begin
      m_tmo[c] = tmo_next(m_tmo[c], compare_match_a[c], compare_match_b[c], tcsr[c*BW +: 4]);
      if (compare_match_a[c])    m_cmfa[c] = 1'b1;
      else if (flag_clr_cmfa[c]) m_cmfa[c] = 1'b0;
      if (compare_match_b[c])    m_cmfb[c] = 1'b1;
      else if (flag_clr_cmfb[c]) m_cmfb[c] = 1'b0;
      if (overflow[c])           m_ovf[c]  = 1'b1;
      else if (flag_clr_ovf[c])  m_ovf[c]  = 1'b0;
      if (tcsr[c*BW+4] && compare_match_a[c]) hit = 1'b1;
      m_hist[c] = {m_hist[c][1:0], tmri[c]};
    end
    m_adc = hit;
  endtask

  task automatic check_all();
    logic [N-1:0]    e_cmia, e_cmib, e_ovi, e_cc;
    logic [N*CW-1:0] e_cs;
    logic            ext;
    for (int c = 0; c < N; c++) begin
      e_cmia[c] = m_cmfa[c] & tcr[c*BW+6];
      e_cmib[c] = m_cmfb[c] & tcr[c*BW+7];
      e_ovi[c]  = m_ovf[c]  & tcr[c*BW+5];
      // Level mode: tmri two edges ago. Pulse mode: rose between three and two edges ago.
      ext = tccr[c*BW+3] ? m_hist[c][1] : (m_hist[c][1] & ~m_hist[c][2]);
      case (tcr[c*BW+3 +: 2])
        2'b01:   e_cc[c] = compare_match_a[c];
        2'b10:   e_cc[c] = compare_match_b[c];
        2'b11:   e_cc[c] = ext;
        default: e_cc[c] = 1'b0;
      endcase
      e_cs[c*CW +: CW] = {tcr[c*BW +: 3], tccr[c*BW +: 2]};
    end
    chk("cmfa", 64'(cmfa), 64'(m_cmfa));
    chk("cmfb", 64'(cmfb), 64'(m_cmfb));
    chk("ovf",  64'(ovf),  64'(m_ovf));
    chk("cmia", 64'(cmia), 64'(e_cmia));
    chk("cmib", 64'(cmib), 64'(e_cmib));
    chk("ovi",  64'(ovi),  64'(e_ovi));
    chk("counter_clear", 64'(counter_clear), 64'(e_cc));
    chk("tmo",  64'(tmo),  64'(m_tmo));
    chk("adc_request", 64'(adc_request), 64'(m_adc));
    chk("clock_select", 64'(clock_select), 64'(e_cs));
  endtask

  // Inputs are driven at the falling edge; outputs are checked 1 ns later,
  // then the model advances on the rising edge.
  task automatic cycle();
    #1;
    check_all();
    @(posedge clk);
    if (!rst) model_tick();
    @(negedge clk);
  endtask

  task automatic clear_strobes();
    compare_match_a = '0; compare_match_b = '0; overflow = '0;
    flag_clr_cmfa = '0; flag_clr_cmfb = '0; flag_clr_ovf = '0;
  endtask

  initial begin
    int cc_sum;
    rst = 1'b1; tmri = '0; tcr = '0; tccr = '0; tcsr = '0;
    clear_strobes();
    model_reset();
    @(negedge clk);
    cycle();
    chk("rst_tmo", 64'(tmo), 64'(INIT));
    chk("rst_adc", 64'(adc_request), 64'd0);
    rst = 1'b0;
    repeat (3) cycle();

    // Ch0 OS=0111: B drives 0, A toggles; tmo0 starts at 0.
    tcsr[7:0] = 8'h07;
    compare_match_a[0] = 1'b1; cycle(); clear_strobes();
    chk("tmo0_toggle_hi", 64'(tmo[0]), 64'd1);
    cycle();
    compare_match_a[0] = 1'b1; cycle(); clear_strobes();
    chk("tmo0_toggle_lo", 64'(tmo[0]), 64'd0);
    compare_match_a[0] = 1'b1; compare_match_b[0] = 1'b1; cycle(); clear_strobes();
    chk("tmo0_b_wins", 64'(tmo[0]), 64'd0);
    tcsr[7:0] = 8'h03;
    compare_match_a[0] = 1'b1; compare_match_b[0] = 1'b1; cycle(); clear_strobes();
    chk("tmo0_b_hold_a_toggle", 64'(tmo[0]), 64'd1);
    compare_match_a[0] = 1'b1; cycle();
    compare_match_a[0] = 1'b1; cycle(); clear_strobes();
    chk("tmo0_back_to_back", 64'(tmo[0]), 64'd1);

    // Ch1 CMIEA: set, clear, then set and clear together.
    tcr[BW +: BW] = 8'h40;
    compare_match_a[1] = 1'b1; cycle(); clear_strobes();
    chk("cmia1_set", 64'(cmia[1]), 64'd1);
    flag_clr_cmfa[1] = 1'b1; cycle(); clear_strobes();
    chk("cmfa1_clr", 64'(cmfa[1]), 64'd0);
    compare_match_a[1] = 1'b1; flag_clr_cmfa[1] = 1'b1; cycle(); clear_strobes();
    chk("cmfa1_set_wins", 64'(cmfa[1]), 64'd1);

    // Ch0 CCLR=11, pulse mode then level mode, tmri0 high for 5 cycles.
    tcr[7:0] = 8'h18; tccr[7:0] = 8'h00;
    cc_sum = 0;
    for (int k = 0; k < 9; k++) begin
      tmri[0] = (k < 5);
      cycle();
      cc_sum += int'(counter_clear[0]);
    end
    chk("tmri_pulse_count", 64'(cc_sum), 64'd1);
    tccr[7:0] = 8'h08;
    cc_sum = 0;
    for (int k = 0; k < 9; k++) begin
      tmri[0] = (k < 5);
      cycle();
      cc_sum += int'(counter_clear[0]);
    end
    chk("tmri_level_count", 64'(cc_sum), 64'd5);

    // ADC trigger from ch0 and ch3, and none without ADTE.
    tcsr[7:0] = 8'h10;
    compare_match_a[0] = 1'b1; cycle(); clear_strobes();
    chk("adc_ch0", 64'(adc_request), 64'd1);
    cycle();
    chk("adc_one_pulse", 64'(adc_request), 64'd0);
    tcsr[7:0] = 8'h00;
    compare_match_a[0] = 1'b1; cycle(); clear_strobes();
    chk("adc_no_adte", 64'(adc_request), 64'd0);
    tcsr[3*BW +: BW] = 8'h10;
    compare_match_a[3] = 1'b1; cycle(); clear_strobes();
    chk("adc_ch3", 64'(adc_request), 64'd1);
    chk("clksel0", 64'(clock_select[CW-1:0]), 64'({tcr[2:0], tccr[1:0]}));

    // Random traffic.
    for (int k = 0; k < 1500; k++) begin
      if (k % 40 == 0) begin
        tcr = 32'($urandom); tccr = 32'($urandom); tcsr = 32'($urandom);
      end
      compare_match_a = N'($urandom & $urandom);
      compare_match_b = N'($urandom & $urandom);
      overflow        = N'($urandom & $urandom);
      flag_clr_cmfa   = N'($urandom & $urandom);
      flag_clr_cmfb   = N'($urandom & $urandom);
      flag_clr_ovf    = N'($urandom & $urandom);
      tmri            = tmri ^ N'($urandom & $urandom & $urandom);
      cycle();
    end
    clear_strobes();

    // Mid-operation reset with tmo0=1 and cmfb0=1.
    tcr = '0; tccr = '0; tcsr = '0; tcsr[7:0] = 8'h08;
    compare_match_b[0] = 1'b1; cycle(); clear_strobes();
    chk("pre_rst_tmo0", 64'(tmo[0]), 64'd1);
    chk("pre_rst_cmfb0", 64'(cmfb[0]), 64'd1);
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst_tmo0", 64'(tmo[0]), 64'(INIT[0]));
    chk("async_rst_cmfb0", 64'(cmfb[0]), 64'd0);
    compare_match_a = '1; compare_match_b = '1; overflow = '1;
    cycle();
    clear_strobes();
    rst = 1'b0;
    repeat (3) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
